// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Purpose  : Shared types and helpers for the pixel-core read cache path.
//             Holds the controller state encoding, the default geometry and
//             the block-index to SDRAM byte-address conversion.
//  Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int SIZE_BLOCK = 32;
    localparam int BIT_TOTAL  = 24;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        FILL     = 3'd4
    } cache_rd_state_e;

    // Block index -> byte address; the caller truncates to its bus width.
    function automatic logic [63:0] blk2byte_addr(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned shift
    );
        return base + (addr << shift);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_rd_ctrl
//  Purpose  : Read cache controller. Accepts one Avalon-MM read at a time,
//             looks it up in a one-cycle cache, and on a miss fetches the
//             block from SDRAM, fills the cache and returns the block.
//  Options  : CACHE_RD_CTRL_PERF_EN adds saturating hit/miss counters
//             (o_hit_cnt, o_miss_cnt).
//  Revision : 1.0 - initial release
// ============================================================================
module cache_rd_ctrl #(
    parameter int                    SIZE_BLOCK = cache_pkg::SIZE_BLOCK,
    parameter int                    BIT_TOTAL  = cache_pkg::BIT_TOTAL,
    parameter int                    MEM_ADDR_W = 32,
    parameter logic [MEM_ADDR_W-1:0] ADDR_BASE  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  s_read,
    input  logic [BIT_TOTAL-1:0]  s_address,
    output logic                  s_waitrequest,
    output logic [SIZE_BLOCK-1:0] s_readdata,
    output logic                  s_readdatavalid,
    output logic                  m_read,
    output logic [MEM_ADDR_W-1:0] m_address,
    input  logic                  m_waitrequest,
    input  logic [SIZE_BLOCK-1:0] m_readdata,
    input  logic                  m_readdatavalid,
    output logic                  c_en,
    output logic                  c_wrt,
    output logic [BIT_TOTAL-1:0]  c_addr,
    output logic [SIZE_BLOCK-1:0] c_wdata,
    input  logic [SIZE_BLOCK-1:0] c_rdata,
    input  logic                  c_success
`ifdef CACHE_RD_CTRL_PERF_EN
    ,
    output logic [31:0]           o_hit_cnt,
    output logic [31:0]           o_miss_cnt
`endif
);
    import cache_pkg::*;

    localparam int unsigned BYTE_SHIFT = $clog2(SIZE_BLOCK / 8);

    cache_rd_state_e        r_state;
    logic [BIT_TOTAL-1:0]   r_addr;
    logic [SIZE_BLOCK-1:0]  r_data;
    logic                   w_accept;

    assign s_waitrequest = i_rst || (r_state != IDLE);
    assign w_accept      = s_read && !s_waitrequest;

    // Cache port: lookup straight from the slave address when idle, fill from
    // the latched address/data; silenced while reset is asserted.
    always_comb begin
        c_en    = w_accept || ((r_state == FILL) && !i_rst);
        c_wrt   = (r_state == FILL) && !i_rst;
        c_addr  = (r_state == IDLE) ? s_address : r_addr;
        c_wdata = r_data;
    end

    // Main control FSM with registered slave response and SDRAM request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_data          <= '0;
            s_readdata      <= '0;
            s_readdatavalid <= 1'b0;
            m_read          <= 1'b0;
            m_address       <= '0;
        end else begin
            s_readdatavalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (s_read) begin
                        r_addr  <= s_address;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (c_success) begin
                        s_readdata      <= c_rdata;
                        s_readdatavalid <= 1'b1;
                        r_state         <= IDLE;
                    end else begin
                        m_read    <= 1'b1;
                        m_address <= MEM_ADDR_W'(blk2byte_addr(64'(r_addr),
                                                               64'(ADDR_BASE),
                                                               BYTE_SHIFT));
                        r_state   <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    // Request and address stay frozen until SDRAM takes them.
                    if (!m_waitrequest) begin
                        m_read  <= 1'b0;
                        r_state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (m_readdatavalid) begin
                        r_data  <= m_readdata;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    s_readdata      <= r_data;
                    s_readdatavalid <= 1'b1;
                    r_state         <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_RD_CTRL_PERF_EN
    // Saturating lookup outcome counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (r_state == LOOKUP) begin
            if (c_success) begin
                if (o_hit_cnt != '1) o_hit_cnt <= o_hit_cnt + 32'd1;
            end else begin
                if (o_miss_cnt != '1) o_miss_cnt <= o_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_rd_ctrl
//  Purpose  : Self-checking bench for cache_rd_ctrl with a direct-mapped
//             cache model, an SDRAM agent and a transaction-level reference.
//  Options  : CACHE_RD_CTRL_PERF_EN enables the counter checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_rd_ctrl;

    localparam int          SB   = 32;
    localparam int          BT   = 24;
    localparam int          MW   = 32;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           s_read = 1'b0;
    logic [BT-1:0]  s_address = '0;
    logic           s_waitrequest;
    logic [SB-1:0]  s_readdata;
    logic           s_readdatavalid;
    logic           m_read;
    logic [MW-1:0]  m_address;
    logic           m_waitrequest;
    logic [SB-1:0]  m_readdata;
    logic           m_readdatavalid;
    logic           c_en;
    logic           c_wrt;
    logic [BT-1:0]  c_addr;
    logic [SB-1:0]  c_wdata;
    logic [SB-1:0]  c_rdata;
    logic           c_success;
`ifdef CACHE_RD_CTRL_PERF_EN
    logic [31:0]    o_hit_cnt;
    logic [31:0]    o_miss_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    cache_rd_ctrl #(
        .SIZE_BLOCK (SB),
        .BIT_TOTAL  (BT),
        .MEM_ADDR_W (MW),
        .ADDR_BASE  (BASE)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .s_read          (s_read),
        .s_address       (s_address),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_read          (m_read),
        .m_address       (m_address),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .c_en            (c_en),
        .c_wrt           (c_wrt),
        .c_addr          (c_addr),
        .c_wdata         (c_wdata),
        .c_rdata         (c_rdata),
        .c_success       (c_success)
`ifdef CACHE_RD_CTRL_PERF_EN
        ,
        .o_hit_cnt       (o_hit_cnt),
        .o_miss_cnt      (o_miss_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // SDRAM contents: one fixed word for the directed address, a hash elsewhere.
    function automatic logic [31:0] mem(input logic [23:0] a);
        if (a == 24'h000010) return 32'hDEAD_BEEF;
        return {a[7:0], a} ^ 32'h3C5A_A5C3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- SDRAM agent ----------------
    int          sd_lat   = 3;
    int          sd_stall = 0;
    int          sd_left;
    int          sd_cnt;
    bit          sd_pend;
    logic [31:0] sd_addr;

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_waitrequest   <= 1'b0;
            m_readdatavalid <= 1'b0;
            m_readdata      <= '0;
            sd_left         <= 0;
            sd_cnt          <= 0;
            sd_pend         <= 1'b0;
        end else begin
            m_readdatavalid <= 1'b0;
            m_readdata      <= $urandom;
            if (m_read && m_waitrequest) begin
                sd_left       <= sd_left - 1;
                m_waitrequest <= (sd_left > 1);
            end else begin
                sd_left       <= sd_stall;
                m_waitrequest <= (sd_stall > 0);
            end
            if (m_read && !m_waitrequest) begin
                sd_pend <= 1'b1;
                sd_cnt  <= sd_lat;
                sd_addr <= m_address;
            end else if (sd_pend) begin
                if (sd_cnt == 1) begin
                    m_readdatavalid <= 1'b1;
                    m_readdata      <= mem(24'((sd_addr - BASE) >> 2));
                    sd_pend         <= 1'b0;
                end else begin
                    sd_cnt <= sd_cnt - 1;
                end
            end
        end
    end

    // ---------------- Direct-mapped cache, 64 lines ----------------
    logic [31:0] cd [64];
    logic [17:0] ct [64];
    bit          cv [64];

    always @(posedge i_clk) begin
        if (c_en && c_wrt) begin
            cv[c_addr[5:0]] <= 1'b1;
            ct[c_addr[5:0]] <= c_addr[23:6];
            cd[c_addr[5:0]] <= c_wdata;
            c_success       <= 1'b1;
            c_rdata         <= $urandom;
        end else if (c_en) begin
            if (cv[c_addr[5:0]] && ct[c_addr[5:0]] == c_addr[23:6]) begin
                c_success <= 1'b1;
                c_rdata   <= cd[c_addr[5:0]];
            end else begin
                c_success <= 1'b0;
                c_rdata   <= $urandom;
            end
        end else begin
            c_success <= 1'($urandom);
            c_rdata   <= $urandom;
        end
    end

    // ---------------- Reference model and compare ----------------
    int          ref_line [64];       // block address resident per line, -1 empty
    bit          infl = 1'b0, t_hit = 1'b0, hs_done = 1'b0, rst_prev = 1'b0;
    int          a_cyc = 0, d_cyc = -1, resp_due = -1;
    logic [23:0] t_addr = '0;
    logic [31:0] last_data = '0, t_maddr = '0;
    int          n_mreq = 0, n_fill = 0, n_mrcyc = 0;
    int          ref_hits = 0, ref_miss = 0;
    int          resp_cnt = 0, res_lat = 0, res_mreq = 0, res_fill = 0, res_mrcyc = 0;
    logic [31:0] res_data = '0, res_maddr = '0;

    always @(negedge i_clk) begin
        bit          busy, resp_now, exp_mr, fill_now, acc;
        logic [31:0] exp_maddr;
        if (i_rst) begin
            chk("rst_waitrequest", s_waitrequest, 1);
            chk("rst_c_en", c_en, 0);
            chk("rst_c_wrt", c_wrt, 0);
            if (rst_prev) begin
                chk("rst_readdatavalid", s_readdatavalid, 0);
                chk("rst_readdata", s_readdata, 0);
                chk("rst_m_read", m_read, 0);
                chk("rst_m_address", m_address, 0);
            end
            infl      = 1'b0;
            last_data = '0;
            rst_prev  = 1'b1;
            ref_hits  = 0;
            ref_miss  = 0;
        end else begin
            rst_prev = 1'b0;
            resp_now = infl && (cyc == resp_due);
            busy     = infl && !resp_now;
            chk("s_waitrequest", s_waitrequest, busy);
            chk("s_readdatavalid", s_readdatavalid, resp_now);
            if (resp_now) begin
                chk("s_readdata", s_readdata, mem(t_addr));
                last_data = mem(t_addr);
                res_lat   = cyc - a_cyc;
                res_mreq  = n_mreq;
                res_fill  = n_fill;
                res_mrcyc = n_mrcyc;
                res_data  = s_readdata;
                res_maddr = t_maddr;
                resp_cnt++;
`ifdef CACHE_RD_CTRL_PERF_EN
                chk("o_hit_cnt", o_hit_cnt, ref_hits);
                chk("o_miss_cnt", o_miss_cnt, ref_miss);
`endif
                infl = 1'b0;
            end else begin
                chk("s_readdata_hold", s_readdata, last_data);
            end

            exp_mr    = infl && !t_hit && !hs_done && (cyc >= a_cyc + 2);
            exp_maddr = BASE + 32'(t_addr) * 32'd4;
            chk("m_read", m_read, exp_mr);
            if (m_read) chk("m_address", m_address, exp_maddr);
            if (infl && m_read) begin
                n_mrcyc++;
                t_maddr = m_address;
                if (!m_waitrequest) begin
                    n_mreq++;
                    hs_done = 1'b1;
                end
            end

            if (infl && !t_hit && hs_done && d_cyc < 0 && m_readdatavalid) begin
                d_cyc    = cyc;
                resp_due = cyc + 2;
            end

            fill_now = infl && !t_hit && (d_cyc >= 0) && (cyc == d_cyc + 1);
            chk("c_wrt", c_wrt, fill_now);
            if (infl && c_wrt) n_fill++;
            if (fill_now) begin
                chk("c_addr_fill", c_addr, t_addr);
                chk("c_wdata", c_wdata, mem(t_addr));
                ref_line[t_addr[5:0]] = int'(t_addr);
            end

            acc = s_read && !busy;
            chk("c_en", c_en, acc || fill_now);
            if (acc) begin
                chk("c_addr_lookup", c_addr, s_address);
                infl     = 1'b1;
                t_addr   = s_address;
                t_hit    = (ref_line[s_address[5:0]] == int'(s_address));
                a_cyc    = cyc;
                hs_done  = 1'b0;
                d_cyc    = -1;
                resp_due = t_hit ? cyc + 2 : -1;
                n_mreq   = 0;
                n_fill   = 0;
                n_mrcyc  = 0;
                t_maddr  = '0;
                if (t_hit) ref_hits++;
                else       ref_miss++;
            end

            if (infl && (cyc - a_cyc > 400)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL txn_timeout: addr %0h no response after %0d cycles", t_addr, cyc - a_cyc);
                infl = 1'b0;
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic issue(input logic [23:0] a);
        int guard = 0;
        s_read    = 1'b1;
        s_address = a;
        @(negedge i_clk);
        while (s_waitrequest && guard < 500) begin
            guard++;
            @(negedge i_clk);
        end
        if (guard >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: addr %0h never accepted, wanted acceptance", a);
        end
        @(posedge i_clk);
        #1;
        s_read    = 1'b0;
        s_address = 24'($urandom);
    endtask

    task automatic rd(input logic [23:0] a);
        int prev = resp_cnt;
        int g    = 0;
        issue(a);
        while (resp_cnt == prev && g < 500) begin
            @(posedge i_clk);
            #1;
            g++;
        end
        repeat (3) @(posedge i_clk);
        #1;
        chk("response_count", resp_cnt, prev + 1);
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        n_cmp++;
        n_bad++;
        $display("FAIL global_timeout: simulation still running, wanted completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int prev;
        int g;
        for (int i = 0; i < 64; i++) ref_line[i] = -1;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Cold miss: 0x10 -> byte address 0x1040, SDRAM latency 3
        sd_lat = 3; sd_stall = 0;
        rd(24'h000010);
        chk("cold_maddr", res_maddr, 32'h0000_1040);
        chk("cold_mreq", res_mreq, 1);
        chk("cold_fill", res_fill, 1);
        chk("cold_data", res_data, 32'hDEAD_BEEF);
        chk("cold_latency", res_lat, 8);

        // Hit after fill
        rd(24'h000010);
        chk("hit_latency", res_lat, 2);
        chk("hit_mreq", res_mreq, 0);
        chk("hit_fill", res_fill, 0);
        chk("hit_data", res_data, 32'hDEAD_BEEF);

        // Conflict on the same line
        rd(24'h000110);
        chk("conflict_mreq", res_mreq, 1);
        chk("conflict_maddr", res_maddr, 32'h0000_1440);
        rd(24'h000010);
        chk("conflict_back_mreq", res_mreq, 1);
        chk("conflict_back_data", res_data, 32'hDEAD_BEEF);

        // SDRAM stall of 5 cycles
        sd_stall = 5;
        rd(24'h000030);
        chk("stall_mread_cycles", res_mrcyc, 6);
        chk("stall_mreq", res_mreq, 1);
        chk("stall_maddr", res_maddr, 32'h0000_10C0);
        sd_stall = 0;

        // Reset while waiting for SDRAM data
        sd_lat = 8;
        issue(24'h000020);
        g = 0;
        do begin
            @(negedge i_clk);
            g++;
        end while (!(m_read && !m_waitrequest) && g < 100);
        @(posedge i_clk);
        #1;
        pulse_reset();
        prev = resp_cnt;
        repeat (12) @(posedge i_clk);
        #1;
        chk("no_resp_after_reset", resp_cnt, prev);
        sd_lat = 3;
        rd(24'h000020);
        chk("post_reset_mreq", res_mreq, 1);
        chk("post_reset_latency", res_lat, 8);

        // Miss, hit, hit, miss from cleared counters
        pulse_reset();
        rd(24'h000031);
        chk("seq_miss1_mreq", res_mreq, 1);
        rd(24'h000031);
        chk("seq_hit1_mreq", res_mreq, 0);
        rd(24'h000031);
        chk("seq_hit2_mreq", res_mreq, 0);
        rd(24'h000071);
        chk("seq_miss2_mreq", res_mreq, 1);
`ifdef CACHE_RD_CTRL_PERF_EN
        chk("perf_hits", o_hit_cnt, 2);
        chk("perf_misses", o_miss_cnt, 2);
`endif

        // Randomized traffic over a small address pool
        for (int n = 0; n < 300; n++) begin
            logic [23:0] a;
            a        = 24'(($urandom_range(0, 2) << 6) | $urandom_range(0, 15));
            sd_lat   = $urandom_range(1, 4);
            sd_stall = $urandom_range(0, 3);
            issue(a);
            repeat ($urandom_range(0, 2)) begin
                @(posedge i_clk);
                #1;
            end
        end
        g = 0;
        while (infl && g < 500) begin
            @(posedge i_clk);
            #1;
            g++;
        end
        repeat (4) @(posedge i_clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_rd_ctrl.md
Name: cache_rd_ctrl

Overview:
- Per-pixel-core read cache controller between the compute modules (intersection/shading Avalon masters) and the SDRAM Avalon master port.
- Accepts one read at a time on an Avalon-MM slave and looks it up in the attached one-cycle read-only cache.
- On a hit, returns the cached block. On a miss, fetches the block from SDRAM, fills the cache, then returns the block.

Parameters:
- SIZE_BLOCK, 32, data width in bits; a power of two, at least 8.
- BIT_TOTAL, 24, block (word) address width on the slave and cache side.
- MEM_ADDR_W, 32, SDRAM byte-address width.
- ADDR_BASE, 32'h0, SDRAM byte base address of the data array.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- s_read  in  1  slave read request
- s_address  in  BIT_TOTAL  block index
- s_waitrequest  out  1  slave stall
- s_readdata  out  SIZE_BLOCK  returned block
- s_readdatavalid  out  1  s_readdata valid for one cycle
- m_read  out  1  SDRAM read request
- m_address  out  MEM_ADDR_W  SDRAM byte address
- m_waitrequest  in  1  SDRAM stall
- m_readdata  in  SIZE_BLOCK  SDRAM data
- m_readdatavalid  in  1  SDRAM data valid
- c_en  out  1  cache enable
- c_wrt  out  1  cache write (fill)
- c_addr  out  BIT_TOTAL  cache index
- c_wdata  out  SIZE_BLOCK  fill data
- c_rdata  in  SIZE_BLOCK  cache output, registered one cycle after c_en
- c_success  in  1  cache hit/ack, registered one cycle after c_en

Behaviour:
- Reset: clock i_clk; reset i_rst, synchronous, active-high.
  - State returns to IDLE.
  - s_readdatavalid=0, s_readdata=0, m_read=0, m_address=0, c_en=0, c_wrt=0.
  - s_waitrequest=1 while i_rst is high.
  - Reset mid-operation abandons the request; no response is produced.
  - i_rst is shared with the SDRAM agent, so no stale m_readdatavalid arrives after reset.
- s_waitrequest = (state != IDLE). A request is accepted when s_read && !s_waitrequest; s_address is latched into addr_q.
- FSM states: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL.
- IDLE:
  - When s_read is high, drive c_en=1, c_wrt=0, c_addr=s_address combinationally, then go to LOOKUP.
- LOOKUP (cache result visible):
  - c_success=1: register s_readdata<=c_rdata and s_readdatavalid<=1, then go to IDLE. Hit latency is 2 cycles from acceptance to readdatavalid.
  - c_success=0: go to MEM_REQ.
- MEM_REQ:
  - m_read=1 and m_address = ADDR_BASE + (addr_q << log2(SIZE_BLOCK/8)), truncated to MEM_ADDR_W.
  - Hold both stable while m_waitrequest=1. On m_waitrequest=0, deassert m_read and go to MEM_WAIT.
- MEM_WAIT:
  - On m_readdatavalid, latch m_readdata into data_q and go to FILL.
  - m_readdatavalid is ignored in all other states.
- FILL:
  - Drive c_en=1, c_wrt=1, c_addr=addr_q, c_wdata=data_q.
  - Register s_readdata<=data_q and s_readdatavalid<=1, then go to IDLE.
  - c_success on the fill is ignored.
- s_readdatavalid is a single-cycle pulse. s_readdata holds its value until the next response.
- A new request may be accepted in the same cycle s_readdatavalid is high (state is IDLE). Back-to-back hits therefore sustain one response every 2 cycles.
- At most one outstanding SDRAM read; no write traffic.

Optional Feature:
- Macro: CACHE_RD_CTRL_PERF_EN.
- When defined:
  - Adds outputs o_hit_cnt and o_miss_cnt, 32 bits each.
  - o_hit_cnt increments on each LOOKUP with c_success=1; o_miss_cnt on each LOOKUP with c_success=0.
  - Both saturate at all-ones and clear on i_rst.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package cache_pkg holds:
  - the state enum typedef cache_rd_state_e;
  - the function blk2byte_addr(addr, base) for the SDRAM address computation;
  - the default localparams SIZE_BLOCK and BIT_TOTAL.
- No sub-module: the FSM and datapath live in one module. A cache_core wrapper instantiating this block plus the cache is built separately.

Test Plan:
- Cold miss: read addr 0x000010 with SDRAM returning 0xDEADBEEF after 3 cycles and ADDR_BASE=0x1000 -> m_address=0x1040, one c_wrt fill, s_readdata=0xDEADBEEF, readdatavalid pulses once.
- Hit after fill: re-read 0x000010 -> no m_read, s_readdatavalid 2 cycles after acceptance, data 0xDEADBEEF.
- Conflict: direct-mapped cache, read 0x000110 (same index, new tag) -> miss, SDRAM fetch; then 0x000010 misses again.
- SDRAM stall: hold m_waitrequest=1 for 5 cycles -> m_read and m_address stable throughout, a single request issued, s_waitrequest high the whole time.
- Reset mid-miss: assert i_rst in MEM_WAIT -> next cycle all outputs at reset values, no s_readdatavalid; the next read behaves as a cold miss.
- Perf (CACHE_RD_CTRL_PERF_EN): sequence miss, hit, hit, miss -> o_hit_cnt=2, o_miss_cnt=2.
